// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg
// Shared types and codes for the datapath micro-sequencer:
//   kind_e   - request kinds (ALU reg-reg, MOVI, MOVR, CMP)
//   state_e  - sequencer FSM states
//   SH_*     - shifter codes understood by the datapath shifter
//   ALU_*    - ALU operation codes understood by the datapath ALU
//   first_state() - first non-idle state visited by a legal request of a kind
package dp_seq_pkg;

    typedef enum logic [1:0] {
        K_ALU  = 2'b00,
        K_MOVI = 2'b01,
        K_MOVR = 2'b10,
        K_CMP  = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LA   = 3'd1,
        S_LB   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // MOVR skips the A load (A is forced to zero in EX); MOVI needs only
    // the writeback of the immediate.
    function automatic state_e first_state(input kind_e k);
        case (k)
            K_MOVR:  return S_LB;
            K_MOVI:  return S_WB;
            default: return S_LA;
        endcase
    endfunction

endpackage

// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl
// Micro-sequencer that turns one request word into the multi-cycle control
// strobe sequence of the register-file / A-B-C / shifter / ALU datapath.
// Moore FSM: every output is decoded from the state and the latched request.
//
// Ports:
//   clk, reset_n           - rising-edge clock, asynchronous active-low reset
//   req_valid / req_ready  - request handshake; ready only while idle
//   req_kind, req_rd, req_rn, req_rm, req_shift, req_aluop, req_imm
//                          - request word, latched on acceptance
//   readnum, writenum, write, vsel          - register file controls
//   loada, loadb, loadc, loads, asel, bsel  - datapath register/mux controls
//   shift, ALUop           - shifter and ALU codes
//   datapath_in            - latched immediate
//   busy, done, err        - status; done/err are one-cycle pulses
module dp_seq_ctrl
    import dp_seq_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 16,
    localparam int REGW = (NREG > 2) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [REGW-1:0] req_rd,
    input  logic [REGW-1:0] req_rn,
    input  logic [REGW-1:0] req_rm,
    input  logic [1:0]      req_shift,
    input  logic [1:0]      req_aluop,
    input  logic [DW-1:0]   req_imm,
    output logic [REGW-1:0] readnum,
    output logic [REGW-1:0] writenum,
    output logic            write,
    output logic            vsel,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            bsel,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic [DW-1:0]   datapath_in,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [REGW:0] NREG_L = (REGW + 1)'(NREG);

    state_e          r_state;
    kind_e           r_kind;
    logic [REGW-1:0] r_rd;
    logic [REGW-1:0] r_rn;
    logic [REGW-1:0] r_rm;
    logic [1:0]      r_shift;
    logic [1:0]      r_aluop;
    logic [DW-1:0]   r_imm;
    // Holds req_ready low through reset and until the first edge after release.
    logic            r_armed;

    state_e          w_next;
    logic            w_accept;
    logic            w_legal;

    function automatic logic idx_ok(input logic [REGW-1:0] idx);
        return ({1'b0, idx} < NREG_L);
    endfunction

    assign req_ready = (r_state == S_IDLE) && r_armed;
    assign w_accept  = req_valid && req_ready;

    // Only indices the kind actually uses are checked.
    always_comb begin
        w_legal = 1'b0;
        case (kind_e'(req_kind))
            K_ALU:   w_legal = idx_ok(req_rd) && idx_ok(req_rn) && idx_ok(req_rm);
            K_MOVI:  w_legal = idx_ok(req_rd);
            K_MOVR:  w_legal = idx_ok(req_rd) && idx_ok(req_rm);
            K_CMP:   w_legal = idx_ok(req_rn) && idx_ok(req_rm);
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_kind  <= K_ALU;
            r_rd    <= '0;
            r_rn    <= '0;
            r_rm    <= '0;
            r_shift <= '0;
            r_aluop <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            if (w_accept) begin
                r_kind  <= kind_e'(req_kind);
                r_rd    <= req_rd;
                r_rn    <= req_rn;
                r_rm    <= req_rm;
                r_shift <= req_shift;
                r_aluop <= req_aluop;
                r_imm   <= req_imm;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        readnum     = '0;
        writenum    = '0;
        write       = 1'b0;
        vsel        = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        shift       = '0;
        ALUop       = '0;
        done        = 1'b0;
        err         = 1'b0;
        busy        = (r_state != S_IDLE);
        datapath_in = r_imm;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_legal ? first_state(kind_e'(req_kind)) : S_ERR;
                end
            end
            S_LA: begin
                readnum = r_rn;
                loada   = 1'b1;
                w_next  = S_LB;
            end
            S_LB: begin
                readnum = r_rm;
                loadb   = 1'b1;
                w_next  = S_EX;
            end
            S_EX: begin
                shift = r_shift;
                ALUop = r_aluop;
                // MOVR computes 0 op shifted(Rm) by forcing A to zero.
                asel  = (r_kind == K_MOVR);
                loadc = (r_kind != K_CMP);
                loads = (r_kind == K_CMP);
                if (r_kind == K_CMP) begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                writenum = r_rd;
                write    = 1'b1;
                vsel     = (r_kind == K_MOVI);
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            S_ERR: begin
                done   = 1'b1;
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dp_seq_ctrl.sv
module tb_dp_seq_ctrl;
    import dp_seq_pkg::*;

    localparam int NREG = 6;
    localparam int DW   = 16;
    localparam int REGW = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_kind;
    logic [REGW-1:0] req_rd, req_rn, req_rm;
    logic [1:0]      req_shift, req_aluop;
    logic [DW-1:0]   req_imm;
    logic [REGW-1:0] readnum, writenum;
    logic            write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]      shift, ALUop;
    logic [DW-1:0]   datapath_in;
    logic            busy, done, err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dp_seq_ctrl #(.NREG(NREG), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
        .req_shift(req_shift), .req_aluop(req_aluop), .req_imm(req_imm),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .datapath_in(datapath_in), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [DW-1:0] f_shift(input logic [DW-1:0] v, input logic [1:0] c);
        case (c)
            SH_NONE: return v;
            SH_LSL:  return v << 1;
            SH_LSR:  return v >> 1;
            default: return {v[DW-1], v[DW-1:1]};
        endcase
    endfunction

    function automatic logic [DW-1:0] f_alu(input logic [DW-1:0] a, b, input logic [1:0] op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            default: return ~b;
        endcase
    endfunction

    // Behavioural datapath driven by the sequencer's control outputs.
    logic [DW-1:0] dp_r [8];
    logic [DW-1:0] dp_a, dp_b, dp_c;
    logic          dp_z;
    logic          dp_clr;
    logic [DW-1:0] dp_ain, dp_bin, dp_out;

    assign dp_ain = asel ? '0 : dp_a;
    assign dp_bin = bsel ? {11'b0, datapath_in[4:0]} : f_shift(dp_b, shift);
    assign dp_out = f_alu(dp_ain, dp_bin, ALUop);

    always @(posedge clk) begin
        if (dp_clr) begin
            for (int i = 0; i < 8; i++) dp_r[i] <= '0;
            dp_a <= '0; dp_b <= '0; dp_c <= '0; dp_z <= 1'b0;
        end else begin
            if (loada) dp_a <= dp_r[readnum];
            if (loadb) dp_b <= dp_r[readnum];
            if (loadc) dp_c <= dp_out;
            if (loads) dp_z <= (dp_out == '0);
            if (write) dp_r[writenum] <= vsel ? datapath_in : dp_c;
        end
    end

    // Reference architectural state.
    logic [DW-1:0] ref_r [8];
    logic          ref_z;

    // Output vector layout:
    // [21] ready [20] busy [19] done [18] err [17] write [16] vsel
    // [15] loada [14] loadb [13] loadc [12] loads [11] asel [10] bsel
    // [9:8] shift [7:6] ALUop [5:3] readnum [2:0] writenum
    localparam logic [21:0] V_RDY  = 22'h200000;
    localparam logic [21:0] V_BUSY = 22'h100000;
    localparam logic [21:0] V_DONE = 22'h080000;
    localparam logic [21:0] V_ERR  = 22'h040000;
    localparam logic [21:0] V_WR   = 22'h020000;
    localparam logic [21:0] V_VSEL = 22'h010000;
    localparam logic [21:0] V_LA   = 22'h008000;
    localparam logic [21:0] V_LB   = 22'h004000;
    localparam logic [21:0] V_LC   = 22'h002000;
    localparam logic [21:0] V_LS   = 22'h001000;
    localparam logic [21:0] V_ASEL = 22'h000800;

    function automatic logic [21:0] f_rn(input logic [2:0] x);
        return {16'b0, x, 3'b0};
    endfunction
    function automatic logic [21:0] f_wn(input logic [2:0] x);
        return {19'b0, x};
    endfunction
    function automatic logic [21:0] f_op(input logic [1:0] sh, input logic [1:0] op);
        return {12'b0, sh, op, 6'b0};
    endfunction

    function automatic logic [21:0] obs();
        return {req_ready, busy, done, err, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, ALUop, readnum, writenum};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++)
            check($sformatf("%s_r%0d", tag, i), 32'(dp_r[i]), 32'(ref_r[i]));
        check($sformatf("%s_z", tag), 32'(dp_z), 32'(ref_z));
    endtask

    // Called and returns at a negative edge. With hold=1 the request stays
    // valid (with scrambled fields) while busy; the next call must follow.
    task automatic run_op(input logic [1:0] k, input logic [2:0] rd, rn, rm,
                          input logic [1:0] sh, op, input logic [DW-1:0] imm, input bit hold);
        logic [21:0] eq[$];
        bit          legal;
        int          n;
        logic [DW-1:0] res;
        req_kind = k; req_rd = rd; req_rn = rn; req_rm = rm;
        req_shift = sh; req_aluop = op; req_imm = imm; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        case (k)
            K_ALU:   legal = (rd < NREG) && (rn < NREG) && (rm < NREG);
            K_MOVI:  legal = (rd < NREG);
            K_MOVR:  legal = (rd < NREG) && (rm < NREG);
            default: legal = (rn < NREG) && (rm < NREG);
        endcase
        if (!legal) begin
            eq.push_back(V_BUSY | V_DONE | V_ERR);
        end else begin
            if (k == K_ALU || k == K_CMP) eq.push_back(V_BUSY | V_LA | f_rn(rn));
            if (k != K_MOVI)              eq.push_back(V_BUSY | V_LB | f_rn(rm));
            if (k == K_ALU)  eq.push_back(V_BUSY | V_LC | f_op(sh, op));
            if (k == K_MOVR) eq.push_back(V_BUSY | V_LC | V_ASEL | f_op(sh, op));
            if (k == K_CMP)  eq.push_back(V_BUSY | V_LS | V_DONE | f_op(sh, op));
            if (k == K_MOVI) eq.push_back(V_BUSY | V_WR | V_VSEL | V_DONE | f_wn(rd));
            else if (k != K_CMP) eq.push_back(V_BUSY | V_WR | V_DONE | f_wn(rd));
        end
        @(posedge clk);
        foreach (eq[i]) begin
            @(negedge clk);
            check($sformatf("k%0d_cyc%0d", k, i + 1), 32'(obs()), 32'(eq[i]));
            if (hold) begin
                req_kind = 2'($urandom_range(0, 3)); req_rd = 3'($urandom_range(0, 7));
                req_rn = 3'($urandom_range(0, 7));   req_rm = 3'($urandom_range(0, 7));
                req_shift = 2'($urandom_range(0, 3)); req_aluop = 2'($urandom_range(0, 3));
                req_imm = 16'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("k%0d_idle", k), 32'(obs()), 32'(V_RDY));
        check($sformatf("k%0d_imm", k), 32'(datapath_in), 32'(imm));
        if (legal) begin
            case (k)
                K_MOVI: ref_r[rd] = imm;
                K_ALU:  ref_r[rd] = f_alu(ref_r[rn], f_shift(ref_r[rm], sh), op);
                K_MOVR: ref_r[rd] = f_alu('0, f_shift(ref_r[rm], sh), op);
                default: begin
                    res = f_alu(ref_r[rn], f_shift(ref_r[rm], sh), op);
                    ref_z = (res == '0);
                end
            endcase
        end
        check_regs($sformatf("k%0d", k));
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_kind = '0; req_rd = '0; req_rn = '0;
        req_rm = '0; req_shift = '0; req_aluop = '0; req_imm = '0; dp_clr = 1'b1;
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        ref_z = 1'b0;
        #1;
        check("rst_outputs", 32'(obs()), 32'd0);
        check("rst_dpin", 32'(datapath_in), 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        dp_clr = 1'b0;
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(obs()), 32'(V_RDY));

        // Directed scenarios
        run_op(K_MOVI, 3'd3, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h0042, 1'b0);
        run_op(K_ALU,  3'd5, 3'd3, 3'd3, SH_NONE, ALU_ADD, 16'h0000, 1'b0);
        check("add_r5", 32'(dp_r[5]), 32'h0084);
        run_op(K_MOVR, 3'd1, 3'd0, 3'd3, SH_LSL, ALU_ADD, 16'h0000, 1'b0);
        check("movr_r1", 32'(dp_r[1]), 32'h0084);
        run_op(K_CMP,  3'd0, 3'd3, 3'd3, SH_NONE, ALU_SUB, 16'h0000, 1'b0);
        check("cmp_z", 32'(dp_z), 32'd1);
        run_op(K_ALU,  3'd2, 3'd1, 3'd7, SH_NONE, ALU_ADD, 16'h0000, 1'b0);
        run_op(K_MOVI, 3'd6, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'hBEEF, 1'b0);
        run_op(K_CMP,  3'd7, 3'd7, 3'd0, SH_NONE, ALU_SUB, 16'h0000, 1'b0);
        run_op(K_MOVI, 3'd2, 3'd7, 3'd7, SH_NONE, ALU_ADD, 16'h1234, 1'b0);
        run_op(K_MOVR, 3'd4, 3'd7, 3'd2, SH_ASR, ALU_ADD, 16'h0000, 1'b0);
        // Held valid and back-to-back
        run_op(K_MOVI, 3'd0, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h8001, 1'b1);
        run_op(K_MOVI, 3'd4, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h7FFE, 1'b1);
        run_op(K_ALU,  3'd5, 3'd0, 3'd4, SH_LSR, ALU_AND, 16'h0000, 1'b1);
        run_op(K_MOVI, 3'd1, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'h0F0F, 1'b0);
        run_op(K_MOVI, 3'd3, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'hF0F0, 1'b0);

        // Reset during EX of an ALU op
        req_kind = K_ALU; req_rd = 3'd5; req_rn = 3'd1; req_rm = 3'd3;
        req_shift = SH_NONE; req_aluop = ALU_ADD; req_imm = 16'h5A5A; req_valid = 1'b1;
        check("rst_test_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2;
        check("rst_test_in_ex", 32'(obs()), 32'(V_BUSY | V_LC | f_op(SH_NONE, ALU_ADD)));
        reset_n = 1'b0;
        #1;
        check("rst_async_out", 32'(obs()), 32'd0);
        check("rst_async_dpin", 32'(datapath_in), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_out", 32'(obs()), 32'd0);
        check_regs("rst_nowrite");
        reset_n = 1'b1;
        #1;
        check("rst_rel_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_rel_idle", 32'(obs()), 32'(V_RDY));
        run_op(K_MOVI, 3'd5, 3'd0, 3'd0, SH_NONE, ALU_ADD, 16'hC0DE, 1'b0);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)),
                   3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   16'($urandom), (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
